// File: rtl/aes_key_sch_ctrl.sv
// aes_key_sch_ctrl: loads an AES-256 key into the key-schedule register and streams its 15 round keys
module aes_key_sch_ctrl #(
  parameter int KEY_W   = 256,
  parameter int RK_W    = 128,
  parameter int STEPS   = 7,
  parameter int LAST_RK = 14
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inKeyValid,
  output logic             outKeyReady,
  output logic             outExtWr,
  output logic             outIntWr,
  input  logic [KEY_W-1:0] inRegData,
  output logic             outRkValid,
  input  logic             inRkReady,
  output logic [3:0]       outRkIdx,
  output logic [RK_W-1:0]  outRkData,
  input  logic             inAbort,
  output logic             outBusy,
  output logic             outDone
);
  localparam int PW = $clog2(STEPS + 1);
  typedef enum logic [2:0] {IDLE, EMIT_EVEN, EMIT_ODD, STEP, DONE} state_t;
  state_t        state_q;
  logic [PW-1:0] pair_q;
  logic          rdy_q;
  logic          odd;
  assign odd         = state_q == EMIT_ODD;
  assign outKeyReady = rdy_q && state_q == IDLE;
  assign outExtWr    = outKeyReady && inKeyValid;
  assign outRkValid  = state_q == EMIT_EVEN || odd;
  assign outRkIdx    = outRkValid ? 4'({pair_q, odd}) : 4'd0;
  assign outRkData   = !outRkValid ? '0 : odd ? inRegData[RK_W-1:0] : inRegData[KEY_W-1:KEY_W-RK_W];
  assign outIntWr    = state_q == STEP && !inAbort;
  assign outDone     = state_q == DONE && !inAbort;
  assign outBusy     = state_q != IDLE;
  // Sequencer: even/odd halves of each register image, then one step commit; abort wins over everything
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q <= IDLE;
      pair_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (inAbort && state_q != IDLE) begin
        state_q <= IDLE;
        pair_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (outExtWr) begin
            state_q <= EMIT_EVEN;
            pair_q  <= '0;
          end
          EMIT_EVEN: if (inRkReady) state_q <= 4'({pair_q, 1'b0}) == 4'(LAST_RK) ? DONE : EMIT_ODD;
          EMIT_ODD:  if (inRkReady) state_q <= STEP;
          STEP: begin
            state_q <= EMIT_EVEN;
            pair_q  <= pair_q + PW'(1);
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_key_sch_ctrl.sv
// tb_aes_key_sch_ctrl: drives the controller against a behavioural key-schedule register and FIPS-197 expansion
module tb_aes_key_sch_ctrl;
  logic         clk = 0;
  logic         rst_n = 1;
  logic         key_valid = 0, rk_ready = 0, abort = 0;
  logic         key_ready, ext_wr, int_wr, rk_valid, busy, done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [255:0] reg_data, key_bus = '0;
  logic [7:0]   rcon;
  logic [31:0]  ew [64];
  logic [127:0] cap [16];
  logic         tv [64], tw [64], td [64], tr [64];
  logic [3:0]   ti [64];
  int           errs = 0, checks = 0, dc;
  logic         ok;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    int         cyc;
    logic       valid;
    logic [3:0] idx;
    logic       intwr;
    logic       done;
    logic       ready;
  } vec_t;
  vec_t tbl [8];

  aes_key_sch_ctrl dut (
    .inClk(clk), .inRstN(rst_n), .inKeyValid(key_valid), .outKeyReady(key_ready),
    .outExtWr(ext_wr), .outIntWr(int_wr), .inRegData(reg_data), .outRkValid(rk_valid),
    .inRkReady(rk_ready), .outRkIdx(rk_idx), .outRkData(rk_data), .inAbort(abort),
    .outBusy(busy), .outDone(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, v);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [255:0] step(input logic [255:0] r, input logic [7:0] rc);
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [255:0] o;
    for (int i = 0; i < 8; i++) w[i] = r[255-32*i -: 32];
    n[0] = w[0] ^ subw({w[7][23:0], w[7][31:24]}) ^ {rc, 24'h0};
    for (int i = 1; i < 8; i++) n[i] = w[i] ^ (i == 4 ? subw(n[3]) : n[i-1]);
    for (int i = 0; i < 8; i++) o[255-32*i -: 32] = n[i];
    return o;
  endfunction

  // Behavioural key-schedule register with its step logic and rcon chain
  always @(posedge clk) begin
    if (ext_wr) begin
      reg_data <= key_bus;
      rcon     <= 8'h01;
    end else if (int_wr) begin
      reg_data <= step(reg_data, rcon);
      rcon     <= gmul(rcon, 8'h02);
    end
  end

  task automatic expand(input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) ew[i] = k[255-32*i -: 32];
    for (int i = 8; i < 64; i++) begin
      t = ew[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) t = subw(t);
      ew[i] = ew[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int i);
    return {ew[4*i], ew[4*i+1], ew[4*i+2], ew[4*i+3]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic rand_key(output logic [255:0] k);
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
  endtask

  task automatic run_key(input logic [255:0] k, input int pct, output int done_cyc);
    int ex, ints;
    logic pv, phs;
    logic [3:0] pi;
    logic [127:0] pd;
    @(negedge clk);
    chk("ready_before_key", key_ready, 1);
    key_bus = k; expand(k); key_valid = 1;
    ex = 0; ints = 0; pv = 0; phs = 0; pi = 0; pd = 0; done_cyc = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      key_valid = 0;
      if (c < 63) begin tv[c] = rk_valid; ti[c] = rk_idx; tw[c] = int_wr; td[c] = done; tr[c] = key_ready; end
      chk("extwr_idle_only", ext_wr, key_ready & key_valid);
      chk("no_ext_int_overlap", ext_wr & int_wr, 0);
      chk("intwr_after_odd", int_wr, phs && pi[0]);
      chk("done_after_rk14", done, phs && pi == 14);
      if (rk_valid) begin
        chk("rk_idx_order", rk_idx, ex[3:0]);
        chk("rk_data", rk_data, ex < 15 ? exp_rk(ex) : '0);
      end
      if (pv && !phs) begin
        chk("stall_valid", rk_valid, 1);
        chk("stall_idx", rk_idx, pi);
        chk("stall_data", rk_data, pd);
      end
      if (int_wr) ints++;
      if (done) begin done_cyc = c; break; end
      rk_ready = $urandom_range(99) < pct;
      phs = rk_valid & rk_ready; pv = rk_valid; pi = rk_idx; pd = rk_data;
      if (phs) begin cap[rk_idx] = rk_data; ex++; end
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("keys_delivered", ex, 15);
    chk("intwr_count", ints, 7);
    @(negedge clk);
    if (done_cyc >= 0 && done_cyc < 62) begin
      tv[done_cyc+1] = rk_valid; ti[done_cyc+1] = rk_idx; tw[done_cyc+1] = int_wr; td[done_cyc+1] = done; tr[done_cyc+1] = key_ready;
    end
    chk("ready_after_done", key_ready, 1);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic go_to(input logic [255:0] k, input logic [3:0] idx, output logic hit);
    @(negedge clk);
    key_bus = k; expand(k); key_valid = 1; rk_ready = 1; hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      key_valid = 0;
      if (rk_valid && rk_idx == idx) begin hit = 1; break; end
    end
    chk("reach_idx", hit, 1);
  endtask

  initial begin
    logic [255:0] k;
    int d;
    tbl[0] = '{1, 1, 0, 0, 0, 0};
    tbl[1] = '{2, 1, 1, 0, 0, 0};
    tbl[2] = '{3, 0, 0, 1, 0, 0};
    tbl[3] = '{4, 1, 2, 0, 0, 0};
    tbl[4] = '{21, 0, 0, 1, 0, 0};
    tbl[5] = '{22, 1, 14, 0, 0, 0};
    tbl[6] = '{23, 0, 0, 0, 1, 0};
    tbl[7] = '{24, 0, 0, 0, 0, 1};
    #1 rst_n = 0;
    key_valid = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", rk_valid, 0);
    chk("rst_idx", rk_idx, 0);
    chk("rst_intwr", int_wr, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_keyready", key_ready, 0);
    chk("rst_extwr", ext_wr, 0);
    key_valid = 0;
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_release", key_ready, 1);

    // T1: consumer always ready, FIPS-197 C.3 key, cycle-exact schedule
    run_key(FIPS_KEY, 100, dc);
    chk("t1_done_cycle", dc, 23);
    foreach (tbl[i]) begin
      chk($sformatf("t1_valid_c%0d", tbl[i].cyc), tv[tbl[i].cyc], tbl[i].valid);
      chk($sformatf("t1_idx_c%0d", tbl[i].cyc), ti[tbl[i].cyc], tbl[i].idx);
      chk($sformatf("t1_intwr_c%0d", tbl[i].cyc), tw[tbl[i].cyc], tbl[i].intwr);
      chk($sformatf("t1_done_c%0d", tbl[i].cyc), td[tbl[i].cyc], tbl[i].done);
      chk($sformatf("t1_ready_c%0d", tbl[i].cyc), tr[tbl[i].cyc], tbl[i].ready);
    end
    chk("fips_rk0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_rk1", cap[1], 128'h101112131415161718191a1b1c1d1e1f);
    chk("fips_rk14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // T2: random keys with a stalling consumer
    for (int r = 0; r < 3; r++) begin
      rand_key(k);
      run_key(k, 30, dc);
    end

    // T3: key offered continuously; next key accepted right after outDone
    @(negedge clk);
    key_bus = FIPS_KEY; expand(FIPS_KEY); key_valid = 1; rk_ready = 1; d = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      chk("t3_extwr", ext_wr, key_ready & key_valid);
      if (done) d = c;
      if (d > 0 && c == d + 1) begin
        chk("t3_ready_after_done", key_ready, 1);
        chk("t3_extwr_after_done", ext_wr, 1);
      end
      if (d > 0 && c == d + 2) begin
        chk("t3_restart_valid", rk_valid, 1);
        chk("t3_restart_idx", rk_idx, 0);
        chk("t3_restart_data", rk_data, exp_rk(0));
        break;
      end
    end
    chk("t3_done_cycle", d, 23);
    key_valid = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t3_abort_idle", busy, 0);

    // T4: abort with idx 5 pending, then a fresh key
    rand_key(k);
    go_to(k, 5, ok);
    rk_ready = 0; abort = 1;
    #1 chk("t4_intwr_masked", int_wr, 0);
    @(negedge clk);
    abort = 0;
    chk("t4_valid_drop", rk_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_ready", key_ready, 1);
    rand_key(k);
    run_key(k, 100, dc);
    chk("t4_restart_done_cycle", dc, 23);
    chk("t4_restart_rk0", cap[0], exp_rk(0));

    // Abort landing on the step cycle must suppress the internal write
    rand_key(k);
    go_to(k, 3, ok);
    @(negedge clk);
    chk("step_reached", int_wr, 1);
    abort = 1;
    #1 chk("step_abort_intwr", int_wr, 0);
    @(negedge clk);
    abort = 0;
    chk("step_abort_idle", busy, 0);

    // T5: asynchronous reset mid-cycle with idx 9 pending
    rand_key(k);
    go_to(k, 9, ok);
    rk_ready = 0; key_valid = 1;
    #2 rst_n = 0;
    #1;
    chk("t5_valid", rk_valid, 0);
    chk("t5_idx", rk_idx, 0);
    chk("t5_data", rk_data, 0);
    chk("t5_intwr", int_wr, 0);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_keyready", key_ready, 0);
    chk("t5_extwr", ext_wr, 0);
    @(negedge clk);
    key_valid = 0; rst_n = 1;
    @(negedge clk);
    chk("t5_ready_after_release", key_ready, 1);

    // T6: abort and ready together on rk14
    rand_key(k);
    go_to(k, 14, ok);
    rk_ready = 0;
    @(negedge clk);
    chk("t6_hold_valid", rk_valid, 1);
    chk("t6_hold_idx", rk_idx, 14);
    chk("t6_hold_data", rk_data, exp_rk(14));
    abort = 1; rk_ready = 1;
    @(negedge clk);
    abort = 0; rk_ready = 0;
    chk("t6_no_done", done, 0);
    chk("t6_valid", rk_valid, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    chk("t6_no_done_later", done, 0);
    chk("t6_ready", key_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
